ctr_down_div: RTL

- Synchronous, cascadable binary down-counter / programmable frequency divider.
- Downstream counterpart of the team's 4-bit up-counter with ripple-carry: it counts down and produces a ripple-borrow (BO) instead of a carry.
- With auto-reload on, it reloads D at terminal count and divides CP by (D+1).
- Used as the divider/timeout element beside the up-counters in the counter library.

---
 rtl/ctr_pkg.sv | 19 +
 rtl/ctr_down4.sv | 30 +++
 rtl/ctr_down_div.sv | 63 ++++++
 3 files changed

// File: rtl/ctr_pkg.sv
// Shared constants and types for the binary counter library (up and down families).
// No logic and no state.
// Holds no flow control.
package ctr_pkg;

  localparam int STAGE_W = 4;

  typedef enum logic {
    WRAP   = 1'b0,
    RELOAD = 1'b1
  } mode_t;

  // Returns the all-ones value of width w, right-aligned in 32 bits.
  function automatic logic [31:0] all_ones(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/ctr_down4.sv
// One 4-bit down-counter stage with a ripple borrow for lookahead cascading.
// Q updates one CP edge after a load or count; BO is combinational.
// Has no backpressure: ENP/ENT gate counting, and n_load/force_load win over counting.
module ctr_down4
  import ctr_pkg::*;
(
  input  logic               CP,
  input  logic               clr,
  input  logic               n_load,
  input  logic               ENP,
  input  logic               ENT,
  input  logic [STAGE_W-1:0] D,
  input  logic               force_load,
  output logic [STAGE_W-1:0] Q,
  output logic               BO
);

  assign BO = ENT & (Q == '0);

  always_ff @(posedge CP or posedge clr) begin
    if (clr) begin
      Q <= '0;
    end else if (!n_load || force_load) begin
      Q <= D;
    end else if (ENP && ENT) begin
      Q <= Q - 4'd1;
    end
  end

endmodule

// File: rtl/ctr_down_div.sv
// Cascadable down-counter and programmable divider built from 4-bit stages.
// Q and div_out update one CP edge after the cause; BO is combinational.
// Has no backpressure: the count stalls while ENP or ENT is low.
module ctr_down_div
  import ctr_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                      CP,
  input  logic                      clr,
  input  logic                      n_load,
  input  logic                      ENP,
  input  logic                      ENT,
  input  logic                      auto_reload,
  input  logic [STAGES*STAGE_W-1:0] D,
  output logic [STAGES*STAGE_W-1:0] Q,
  output logic                      BO,
  output logic                      div_out
);

  localparam int W = STAGES * STAGE_W;

  logic [STAGES:0] ent_chain;
  mode_t           mode;
  logic            tc_zero;
  logic            tc_step;
  logic            force_load;

  assign mode       = auto_reload ? RELOAD : WRAP;
  assign tc_zero    = (Q == {W{1'b0}});
  assign tc_step    = ENP & ENT & tc_zero;
  // In wrap mode every stage sees its borrow-in at zero and steps to F by itself.
  assign force_load = tc_step & (mode == RELOAD);

  assign ent_chain[0] = ENT;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ctr_down4 u_stage (
      .CP         (CP),
      .clr        (clr),
      .n_load     (n_load),
      .ENP        (ENP),
      .ENT        (ent_chain[k]),
      .D          (D[k*STAGE_W +: STAGE_W]),
      .force_load (force_load),
      .Q          (Q[k*STAGE_W +: STAGE_W]),
      .BO         (ent_chain[k+1])
    );
  end

  assign BO = ent_chain[STAGES];

  always_ff @(posedge CP or posedge clr) begin
    if (clr) begin
      div_out <= 1'b0;
    end else if (!n_load) begin
      div_out <= 1'b0;
    end else begin
      div_out <= tc_step;
    end
  end

endmodule
